// File: rtl/fft_buf_pkg.sv
// Shared types, constants and helper functions for the FFT result buffer.
package fft_buf_pkg;

    localparam int unsigned FFT_N_POINTS = 16;
    localparam int unsigned FFT_DATA_W   = 16;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

    function automatic int unsigned bitrev(input int unsigned value, input int unsigned width);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < width) r = r | (((value >> i) & 32'd1) << (width - 1 - i));
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_buf_bank.sv
// One bank of N_POINTS complex words: full-frame parallel write, two async read ports.
module fft_buf_bank
    import fft_buf_pkg::*;
#(
    parameter int unsigned N_POINTS = FFT_N_POINTS,
    parameter int unsigned DATA_W   = FFT_DATA_W,
    localparam int unsigned AW      = clog2(N_POINTS)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [N_POINTS*DATA_W-1:0] wr_r,
    input  logic [N_POINTS*DATA_W-1:0] wr_i,
    input  logic [AW-1:0]              s_addr,
    output logic [DATA_W-1:0]          s_r,
    output logic [DATA_W-1:0]          s_i,
    input  logic [AW-1:0]              r_addr,
    output logic [DATA_W-1:0]          r_r,
    output logic [DATA_W-1:0]          r_i
);

    logic [DATA_W-1:0] mem_r [N_POINTS];
    logic [DATA_W-1:0] mem_i [N_POINTS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned k = 0; k < N_POINTS; k++) begin
                mem_r[k] <= wr_r[k*DATA_W +: DATA_W];
                mem_i[k] <= wr_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign s_r = mem_r[s_addr];
    assign s_i = mem_i[s_addr];
    assign r_r = mem_r[r_addr];
    assign r_i = mem_i[r_addr];

endmodule

// File: rtl/fft_result_buffer.sv
// Ping-pong FFT result buffer: single-edge frame capture, registered random read,
// and valid/ready streaming readout in natural or bit-reversed order.
module fft_result_buffer
    import fft_buf_pkg::*;
#(
    parameter int unsigned N_POINTS = FFT_N_POINTS,
    parameter int unsigned DATA_W   = FFT_DATA_W,
    parameter int unsigned BIT_REV  = 1,
    localparam int unsigned AW      = clog2(N_POINTS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [N_POINTS*DATA_W-1:0] din_r,
    input  logic [N_POINTS*DATA_W-1:0] din_i,
    input  logic                       start,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_r,
    output logic [DATA_W-1:0]          out_i,
    output logic [AW-1:0]              out_idx,
    output logic                       out_last,
    input  logic                       rd_en,
    input  logic [AW-1:0]              rd_addr,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data_r,
    output logic [DATA_W-1:0]          rd_data_i,
    output logic                       frame_avail,
    output logic                       busy,
    output logic                       overflow
);

    state_t state, state_nxt;
    logic   bank_sel, pending;
    logic   start_ok, hs, last_hs, swap;

    logic [AW-1:0]     next_k, s_addr;
    logic [DATA_W-1:0] s0_r, s0_i, s1_r, s1_i;
    logic [DATA_W-1:0] r0_r, r0_i, r1_r, r1_i;

    fft_buf_bank #(.N_POINTS(N_POINTS), .DATA_W(DATA_W)) u_bank0 (
        .clk(clk), .we(load && bank_sel), .wr_r(din_r), .wr_i(din_i),
        .s_addr(s_addr), .s_r(s0_r), .s_i(s0_i),
        .r_addr(rd_addr), .r_r(r0_r), .r_i(r0_i)
    );

    fft_buf_bank #(.N_POINTS(N_POINTS), .DATA_W(DATA_W)) u_bank1 (
        .clk(clk), .we(load && !bank_sel), .wr_r(din_r), .wr_i(din_i),
        .s_addr(s_addr), .s_r(s1_r), .s_i(s1_i),
        .r_addr(rd_addr), .r_r(r1_r), .r_i(r1_i)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = STREAM;
            STREAM:  if (last_hs)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == STREAM);
        start_ok = (state == IDLE) && start && (frame_avail || load);
        hs       = (state == STREAM) && out_valid && out_ready;
        last_hs  = hs && out_last;
        swap     = ((state == IDLE) && load) || (last_hs && (pending || load));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_sel    <= 1'b0;
            pending     <= 1'b0;
            frame_avail <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            overflow    <= load && pending;
            frame_avail <= frame_avail || swap;
            if (swap) bank_sel <= ~bank_sel;
            if (state == STREAM) pending <= last_hs ? 1'b0 : (pending || load);
        end
    end

    // Output registers are loaded from the address of the beat that follows.
    always_comb begin
        next_k = start_ok ? '0 : out_idx + 1'b1;
        s_addr = (BIT_REV != 0) ? AW'(bitrev(32'(next_k), AW)) : next_k;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_r     <= '0;
            out_i     <= '0;
        end else if (start_ok) begin
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_idx   <= '0;
            // Beat 0 of a frame captured on this same edge is not in the bank yet.
            out_r     <= load ? din_r[DATA_W-1:0] : (bank_sel ? s1_r : s0_r);
            out_i     <= load ? din_i[DATA_W-1:0] : (bank_sel ? s1_i : s0_i);
        end else if (hs) begin
            if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                out_idx  <= next_k;
                out_r    <= bank_sel ? s1_r : s0_r;
                out_i    <= bank_sel ? s1_i : s0_i;
                out_last <= (next_k == AW'(N_POINTS - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_data_r <= '0;
            rd_data_i <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data_r <= bank_sel ? r1_r : r0_r;
                rd_data_i <= bank_sel ? r1_i : r0_i;
            end
        end
    end

endmodule

// File: tb/tb_fft_result_buffer.sv
// Self-checking bench: bit-reversed and natural-order instances driven in lockstep
// against a frame-level model of the ping-pong buffer.
module tb_fft_result_buffer;

    localparam int N = 16;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n, load, start, out_ready, rd_en;
    logic [N*W-1:0] din_r, din_i;
    logic [3:0]     rd_addr;

    logic         a_valid, a_last, a_rdv, a_avail, a_busy, a_ovf;
    logic [W-1:0] a_r, a_i, a_rdr, a_rdi;
    logic [3:0]   a_idx;
    logic         b_valid, b_last, b_rdv, b_avail, b_busy, b_ovf;
    logic [W-1:0] b_r, b_i, b_rdr, b_rdi;
    logic [3:0]   b_idx;

    logic [W-1:0] cur_r [N];
    logic [W-1:0] cur_i [N];
    logic [W-1:0] pnd_r [N];
    logic [W-1:0] pnd_i [N];
    logic [W-1:0] new_r [N];
    logic [W-1:0] new_i [N];
    bit m_pend;
    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    fft_result_buffer #(.N_POINTS(N), .DATA_W(W), .BIT_REV(1)) dut_rev (
        .clk(clk), .rst_n(rst_n), .load(load), .din_r(din_r), .din_i(din_i),
        .start(start), .out_valid(a_valid), .out_ready(out_ready),
        .out_r(a_r), .out_i(a_i), .out_idx(a_idx), .out_last(a_last),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(a_rdv),
        .rd_data_r(a_rdr), .rd_data_i(a_rdi),
        .frame_avail(a_avail), .busy(a_busy), .overflow(a_ovf)
    );

    fft_result_buffer #(.N_POINTS(N), .DATA_W(W), .BIT_REV(0)) dut_nat (
        .clk(clk), .rst_n(rst_n), .load(load), .din_r(din_r), .din_i(din_i),
        .start(start), .out_valid(b_valid), .out_ready(out_ready),
        .out_r(b_r), .out_i(b_i), .out_idx(b_idx), .out_last(b_last),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(b_rdv),
        .rd_data_r(b_rdr), .rd_data_i(b_rdi),
        .frame_avail(b_avail), .busy(b_busy), .overflow(b_ovf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int brev(input int k);
        int r = 0;
        for (int b = 0; b < 4; b++) r = r * 2 + ((k >> b) & 1);
        return r;
    endfunction

    // kind 0: ramp with negated imag; kind 1: 0x100+k real; kind 2: fully random
    task automatic gen_frame(input int kind);
        for (int k = 0; k < N; k++) begin
            new_r[k] = (kind == 0) ? 16'(k) : (kind == 1) ? 16'(256 + k) : 16'($urandom);
            new_i[k] = (kind == 0) ? 16'(0 - k) : 16'($urandom);
            din_r[k*W +: W] = new_r[k];
            din_i[k*W +: W] = new_i[k];
        end
    endtask

    task automatic take_new;
        for (int k = 0; k < N; k++) begin
            cur_r[k] = new_r[k];
            cur_i[k] = new_i[k];
        end
    endtask

    task automatic do_load(input int kind);
        gen_frame(kind);
        load = 1'b1;
        tick();
        load = 1'b0;
        take_new();
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // pat 0: always ready, 1: alternating, 2: random. ld1/ld2: loop cycles with a load.
    task automatic stream(input int pat, input int ld1, input int ld2);
        int beats = 0;
        int cyc = 0;
        bit rdy, exp_ovf, nxt_ovf;
        exp_ovf = 1'b0;
        while (beats < N && cyc < 200) begin
            rdy = (pat == 0) ? 1'b1 : (pat == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            out_ready = rdy;
            if (cyc == ld1 || cyc == ld2) begin
                gen_frame(cyc == ld1 ? 1 : 2);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            vec++;
            if ({a_valid, a_idx, a_r, a_i, a_last} !==
                {1'b1, 4'(beats), cur_r[brev(beats)], cur_i[brev(beats)], 1'(beats == N - 1)}) begin
                errs++;
                $display("FAIL beat_rev cyc=%0d got v=%b idx=%0d r=%h i=%h last=%b want idx=%0d r=%h i=%h",
                         cyc, a_valid, a_idx, a_r, a_i, a_last, beats, cur_r[brev(beats)], cur_i[brev(beats)]);
            end
            vec++;
            if ({b_valid, b_idx, b_r, b_i, b_last} !==
                {1'b1, 4'(beats), cur_r[beats], cur_i[beats], 1'(beats == N - 1)}) begin
                errs++;
                $display("FAIL beat_nat cyc=%0d got v=%b idx=%0d r=%h i=%h last=%b want idx=%0d r=%h i=%h",
                         cyc, b_valid, b_idx, b_r, b_i, b_last, beats, cur_r[beats], cur_i[beats]);
            end
            vec++;
            if ({a_ovf, b_ovf} !== {exp_ovf, exp_ovf}) begin
                errs++;
                $display("FAIL overflow cyc=%0d got %b%b want %b", cyc, a_ovf, b_ovf, exp_ovf);
            end
            nxt_ovf = load && m_pend;
            if (load) begin
                for (int k = 0; k < N; k++) begin
                    pnd_r[k] = new_r[k];
                    pnd_i[k] = new_i[k];
                end
                m_pend = 1'b1;
            end
            if (rdy) beats++;
            if (rdy && beats == N && m_pend) begin
                for (int k = 0; k < N; k++) begin
                    cur_r[k] = pnd_r[k];
                    cur_i[k] = pnd_i[k];
                end
                m_pend = 1'b0;
            end
            tick();
            exp_ovf = nxt_ovf;
            cyc++;
        end
        load = 1'b0;
        out_ready = 1'b1;
        vec++;
        if (beats != N) begin
            errs++;
            $display("FAIL stream_timeout got %0d beats want %0d", beats, N);
        end
        vec++;
        if ({a_valid, a_busy, b_valid, b_busy, a_ovf} !== {4'b0000, exp_ovf}) begin
            errs++;
            $display("FAIL stream_end got valid/busy %b%b %b%b ovf=%b want 0000 ovf=%b",
                     a_valid, a_busy, b_valid, b_busy, a_ovf, exp_ovf);
        end
    endtask

    task automatic check_read(input int addr, input logic [W-1:0] er, input logic [W-1:0] ei, input string nm);
        vec++;
        if ({a_rdv, a_rdr, a_rdi, b_rdv, b_rdr, b_rdi} !== {1'b1, er, ei, 1'b1, er, ei}) begin
            errs++;
            $display("FAIL %s addr=%0d got v=%b %h/%h (nat v=%b %h/%h) want %h/%h",
                     nm, addr, a_rdv, a_rdr, a_rdi, b_rdv, b_rdr, b_rdi, er, ei);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        vec++;
        if ({a_valid, a_last, a_idx, a_r, a_i, a_rdv, a_rdr, a_rdi, a_busy, a_ovf, a_avail} !== '0) begin
            errs++;
            $display("FAIL reset_values got v=%b last=%b idx=%h r=%h i=%h rdv=%b rd=%h/%h busy=%b ovf=%b avail=%b want all 0",
                     a_valid, a_last, a_idx, a_r, a_i, a_rdv, a_rdr, a_rdi, a_busy, a_ovf, a_avail);
        end
        rst_n = 1'b1;
        do_start();
        for (int c = 0; c < 20; c++) begin
            vec++;
            if ({a_valid, b_valid, a_avail, b_avail} !== 4'b0000) begin
                errs++;
                $display("FAIL start_no_frame cyc=%0d got valid=%b%b avail=%b%b want 0000",
                         c, a_valid, b_valid, a_avail, b_avail);
            end
            tick();
        end
    endtask

    task automatic test_order;
        do_load(0);
        do_start();
        stream(0, -1, -1);
    endtask

    task automatic test_ready_toggle;
        do_start();
        stream(1, -1, -1);
    endtask

    task automatic test_midstream_load;
        do_load(0);
        do_start();
        stream(0, 4, -1);
        rd_en = 1'b1;
        rd_addr = 4'd3;
        tick();
        rd_en = 1'b0;
        vec++;
        if ({a_rdv, a_rdr} !== {1'b1, 16'h0103}) begin
            errs++;
            $display("FAIL read_frame_b got v=%b r=%h want v=1 r=0103", a_rdv, a_rdr);
        end
        check_read(3, cur_r[3], cur_i[3], "read_frame_b_model");
        do_start();
        stream(1, 3, 9);
        for (int j = 0; j < 4; j++) begin
            rd_addr = 4'($urandom_range(0, N - 1));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            check_read(rd_addr, cur_r[rd_addr], cur_i[rd_addr], "read_frame_c");
        end
    endtask

    task automatic test_random_read;
        logic [3:0] a;
        for (int j = 0; j < 6; j++) begin
            rd_addr = 4'($urandom_range(0, N - 1));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            check_read(rd_addr, cur_r[rd_addr], cur_i[rd_addr], "read_random");
        end
        a = 4'($urandom_range(0, N - 1));
        rd_addr = a;
        rd_en = 1'b1;
        gen_frame(2);
        load = 1'b1;
        tick();
        load = 1'b0;
        check_read(a, cur_r[a], cur_i[a], "read_during_swap");
        take_new();
        tick();
        rd_en = 1'b0;
        check_read(a, cur_r[a], cur_i[a], "read_after_swap");
    endtask

    task automatic test_back_to_back;
        for (int j = 0; j < 3; j++) begin
            gen_frame(2);
            load = 1'b1;
            start = 1'b1;
            tick();
            load = 1'b0;
            start = 1'b0;
            take_new();
            stream(2, -1, -1);
        end
    endtask

    task automatic test_reset_midstream;
        do_load(2);
        do_start();
        out_ready = 1'b1;
        repeat (5) tick();
        vec++;
        if ({a_valid, a_idx, b_idx} !== {1'b1, 4'd5, 4'd5}) begin
            errs++;
            $display("FAIL beat5_reached got v=%b idx=%0d/%0d want 1 5/5", a_valid, a_idx, b_idx);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vec++;
        if ({a_valid, a_busy, a_avail, b_valid, b_busy, b_avail} !== 6'b0) begin
            errs++;
            $display("FAIL reset_abort got %b%b%b %b%b%b want 000 000",
                     a_valid, a_busy, a_avail, b_valid, b_busy, b_avail);
        end
        m_pend = 1'b0;
        do_start();
        for (int c = 0; c < 5; c++) begin
            vec++;
            if ({a_valid, b_valid, a_busy} !== 3'b000) begin
                errs++;
                $display("FAIL start_after_reset cyc=%0d got valid=%b%b busy=%b want 000", c, a_valid, b_valid, a_busy);
            end
            tick();
        end
        do_load(2);
        vec++;
        if ({a_avail, b_avail} !== 2'b11) begin
            errs++;
            $display("FAIL avail_after_load got %b%b want 11", a_avail, b_avail);
        end
        do_start();
        stream(0, -1, -1);
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        rd_en = 1'b0;
        rd_addr = '0;
        din_r = '0;
        din_i = '0;
        m_pend = 1'b0;
        test_reset();
        test_order();
        test_ready_toggle();
        test_midstream_load();
        test_random_read();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
